// File: rtl/vdp_cmd_throttle.sv
// VDP command-slot pacing: fractional accumulator fed from a writable per-context/per-command increment RAM.
// Optional grant statistics counter enabled by defining VDP_THROTTLE_STATS_EN.
module vdp_cmd_throttle #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             CLK21M,
    input  logic             RESET,
    input  logic [3:0]       VDP_COMMAND,
    input  logic             VDPR9PALMODE,
    input  logic             REG_R1_DISP_ON,
    input  logic             REG_R8_SP_OFF,
    input  logic             REG_R9_Y_DOTS,
    input  logic             VDPSPEEDMODE,
    input  logic             DRIVE,
    input  logic             TBL_WE,
    input  logic [7:0]       TBL_ADDR,
    input  logic [ACC_W-1:0] TBL_WDATA,
    output logic             INIT_BUSY,
    output logic             ACTIVE
`ifdef VDP_THROTTLE_STATS_EN
    ,
    output logic [15:0]      GRANT_CNT,
    input  logic             GRANT_CLR
`endif
);

    localparam int unsigned TBL_DEPTH = 256;
    localparam int unsigned INIT_W    = 9;
    localparam logic [ACC_W-1:0] DEF  = {1'b1, {(ACC_W-1){1'b0}}};

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              state_q, state_nxt;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_nxt;
    logic              mem_we_c;
    logic [7:0]        mem_waddr_c;
    logic [ACC_W-1:0]  mem_wdata_c;

    logic [ACC_W-1:0]  tbl [TBL_DEPTH];
    logic [ACC_W-1:0]  incr_q;
    logic [ACC_W-1:0]  acc_q;
    logic [3:0]        cmd_q;
    logic [3:0]        ctx_c;
    logic [7:0]        rd_addr_c;

    // Display-off collapses sprite/line-count bits so blank screens share one context per refresh rate
    assign ctx_c     = {VDPR9PALMODE, REG_R1_DISP_ON,
                        REG_R1_DISP_ON & ~REG_R8_SP_OFF,
                        REG_R1_DISP_ON & REG_R9_Y_DOTS};
    assign rd_addr_c = {ctx_c, VDP_COMMAND};

    always_ff @(posedge CLK21M) begin
        if (RESET) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            init_cnt_q <= init_cnt_nxt;
        end
    end

    // Init fills every entry with DEF, then hands the write port to the host
    always_comb begin
        state_nxt    = state_q;
        init_cnt_nxt = init_cnt_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = TBL_ADDR;
        mem_wdata_c  = TBL_WDATA;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q[INIT_W-1]) begin
                    state_nxt = ST_RUN;
                end else begin
                    mem_we_c     = 1'b1;
                    mem_waddr_c  = init_cnt_q[7:0];
                    mem_wdata_c  = DEF;
                    init_cnt_nxt = init_cnt_q + INIT_W'(1);
                end
            end
            default: begin
                mem_we_c = TBL_WE;
            end
        endcase
    end

    always_ff @(posedge CLK21M) begin
        if (mem_we_c && !RESET) begin
            tbl[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read is registered, so a same-edge write returns the old entry
    always_ff @(posedge CLK21M) begin
        if (RESET) begin
            incr_q <= '0;
        end else if (state_q == ST_RUN) begin
            incr_q <= tbl[rd_addr_c];
        end
    end

    // Command change drops accumulated credit and wins over DRIVE
    always_ff @(posedge CLK21M) begin
        if (RESET) begin
            acc_q <= '0;
            cmd_q <= VDP_COMMAND;
        end else begin
            cmd_q <= VDP_COMMAND;
            if (VDP_COMMAND != cmd_q) begin
                acc_q <= '0;
            end else if ((state_q == ST_RUN) && DRIVE) begin
                acc_q <= {1'b0, acc_q[ACC_W-2:0]} + incr_q;
            end
        end
    end

    assign INIT_BUSY = (state_q == ST_INIT);
    assign ACTIVE    = acc_q[ACC_W-1] | VDPSPEEDMODE | INIT_BUSY;

`ifdef VDP_THROTTLE_STATS_EN
    logic [15:0] grant_cnt_q;

    always_ff @(posedge CLK21M) begin
        if (RESET) begin
            grant_cnt_q <= '0;
        end else if (GRANT_CLR) begin
            grant_cnt_q <= '0;
        end else if (DRIVE && ACTIVE && !INIT_BUSY && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign GRANT_CNT = grant_cnt_q;
`endif

endmodule

// File: tb/tb_vdp_cmd_throttle.sv
// Scoreboard bench for vdp_cmd_throttle: directed stimulus queues expected outputs per cycle, a monitor checks them.
module tb_vdp_cmd_throttle;

    logic        CLK21M;
    logic        RESET;
    logic [3:0]  VDP_COMMAND;
    logic        VDPR9PALMODE;
    logic        REG_R1_DISP_ON;
    logic        REG_R8_SP_OFF;
    logic        REG_R9_Y_DOTS;
    logic        VDPSPEEDMODE;
    logic        DRIVE;
    logic        TBL_WE;
    logic [7:0]  TBL_ADDR;
    logic [15:0] TBL_WDATA;
    logic        INIT_BUSY;
    logic        ACTIVE;
`ifdef VDP_THROTTLE_STATS_EN
    logic [15:0] GRANT_CNT;
    logic        GRANT_CLR;
`endif

    vdp_cmd_throttle #(.ACC_W(16)) dut (
        .CLK21M         (CLK21M),
        .RESET          (RESET),
        .VDP_COMMAND    (VDP_COMMAND),
        .VDPR9PALMODE   (VDPR9PALMODE),
        .REG_R1_DISP_ON (REG_R1_DISP_ON),
        .REG_R8_SP_OFF  (REG_R8_SP_OFF),
        .REG_R9_Y_DOTS  (REG_R9_Y_DOTS),
        .VDPSPEEDMODE   (VDPSPEEDMODE),
        .DRIVE          (DRIVE),
        .TBL_WE         (TBL_WE),
        .TBL_ADDR       (TBL_ADDR),
        .TBL_WDATA      (TBL_WDATA),
        .INIT_BUSY      (INIT_BUSY),
        .ACTIVE         (ACTIVE)
`ifdef VDP_THROTTLE_STATS_EN
        ,
        .GRANT_CNT      (GRANT_CNT),
        .GRANT_CLR      (GRANT_CLR)
`endif
    );

    localparam int SIG_ACT  = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_CNT  = 2;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mon_act;

    initial CLK21M = 1'b0;
    always #5 CLK21M = ~CLK21M;

    always @(posedge CLK21M) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int sig, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK21M);
    endtask

    function automatic logic [15:0] sample(input int sig);
        logic [15:0] v;
        v = 16'hDEAD;
        if (sig == SIG_ACT)  v = {15'd0, ACTIVE};
        if (sig == SIG_BUSY) v = {15'd0, INIT_BUSY};
`ifdef VDP_THROTTLE_STATS_EN
        if (sig == SIG_CNT)  v = GRANT_CNT;
`endif
        return v;
    endfunction

    // Monitor: settles after the stimulus edge, then checks every expectation due this cycle
    always @(negedge CLK21M) begin
        int i;
        #2;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc <= cyc) begin
                mon_act  = sample(sbq[i].sig);
                n_checks = n_checks + 1;
                if ((sbq[i].cyc != cyc) || (mon_act !== sbq[i].exp)) begin
                    n_errors = n_errors + 1;
                    $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h",
                             sbq[i].name, cyc, sbq[i].cyc, mon_act, sbq[i].exp);
                end
                sbq.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, t, s, m;
        RESET          = 1'b1;
        VDP_COMMAND    = 4'h7;
        VDPR9PALMODE   = 1'b0;
        REG_R1_DISP_ON = 1'b0;
        REG_R8_SP_OFF  = 1'b0;
        REG_R9_Y_DOTS  = 1'b0;
        VDPSPEEDMODE   = 1'b0;
        DRIVE          = 1'b0;
        // Host write attempt during init must be ignored
        TBL_WE         = 1'b1;
        TBL_ADDR       = 8'h07;
        TBL_WDATA      = 16'h0000;
`ifdef VDP_THROTTLE_STATS_EN
        GRANT_CLR      = 1'b0;
`endif
        step(3);
        expect_at(cyc, SIG_ACT,  16'd1, "rst_active");
        expect_at(cyc, SIG_BUSY, 16'd1, "rst_busy");
        n_checks = n_checks + 1;
        if (ACTIVE !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL rst_active_direct cyc=%0d actual=%b required=1", cyc, ACTIVE);
        end

        // Reset mid-init: the fill must restart from address 0
        RESET = 1'b0;
        step(100);
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        c0 = cyc;
        expect_at(c0 + 1,   SIG_BUSY, 16'd1, "init_busy_first");
        expect_at(c0 + 256, SIG_BUSY, 16'd1, "init_busy_last");
        expect_at(c0 + 256, SIG_ACT,  16'd1, "init_active_last");
        expect_at(c0 + 257, SIG_BUSY, 16'd0, "init_done_busy");
        expect_at(c0 + 257, SIG_ACT,  16'd0, "init_done_active");
        step(257);
        n_checks = n_checks + 1;
        if (INIT_BUSY !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL init_done_direct cyc=%0d actual=%b required=0", cyc, INIT_BUSY);
        end

        // Default entry: first drive uses INCR=0, every later drive grants
        TBL_WE = 1'b0;
        DRIVE  = 1'b1;
        t = cyc;
        expect_at(t + 1, SIG_ACT, 16'd0, "dflt_first_drive");
        for (int k = 2; k <= 64; k++) expect_at(t + k, SIG_ACT, 16'd1, "dflt_drive");
        step(64);
        DRIVE = 1'b0;

        // Programmed rate 0x2000 in ctx 0111, cmd C: one grant every 4th drive
        t = cyc;
        TBL_WE         = 1'b1;
        TBL_ADDR       = 8'h7C;
        TBL_WDATA      = 16'h2000;
        REG_R1_DISP_ON = 1'b1;
        REG_R9_Y_DOTS  = 1'b1;
        VDP_COMMAND    = 4'hC;
        expect_at(t + 1, SIG_ACT, 16'd0, "rate_cmd_change");
        step(1);
        TBL_WE = 1'b0;
        step(1);
        DRIVE = 1'b1;
        t = cyc;
        for (int n = 1; n <= 400; n++)
            expect_at(t + n, SIG_ACT, (n % 4 == 0) ? 16'd1 : 16'd0, "rate_drive");
        step(400);
        DRIVE = 1'b0;

        // Command change discards credit and a coincident drive
        t = cyc;
        TBL_WE      = 1'b1;
        TBL_ADDR    = 8'h78;
        TBL_WDATA   = 16'h7F00;
        VDP_COMMAND = 4'h8;
        expect_at(t + 1, SIG_ACT, 16'd0, "cc_load");
        step(1);
        TBL_WE = 1'b0;
        step(1);
        DRIVE = 1'b1;
        expect_at(t + 3, SIG_ACT, 16'd0, "cc_acc_7f00");
        step(1);
        VDP_COMMAND = 4'h9;
        expect_at(t + 4, SIG_ACT, 16'd0, "cc_drive_discarded");
        step(1);
        expect_at(t + 5, SIG_ACT, 16'd1, "cc_new_cmd_grant");
        step(1);
        VDP_COMMAND = 4'h8;
        DRIVE       = 1'b0;
        expect_at(t + 6, SIG_ACT, 16'd0, "cc_msb_cleared");
        step(1);
        n_checks = n_checks + 1;
        if (ACTIVE !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL cc_msb_cleared_direct cyc=%0d actual=%b required=0", cyc, ACTIVE);
        end

        // Zero entry never grants; speed mode overrides combinationally
        s = cyc;
        TBL_WE      = 1'b1;
        TBL_ADDR    = 8'h7A;
        TBL_WDATA   = 16'h0000;
        VDP_COMMAND = 4'hA;
        expect_at(s + 1, SIG_ACT, 16'd0, "spd_cmd_change");
        step(1);
        TBL_WE = 1'b0;
        step(1);
        DRIVE = 1'b1;
        expect_at(s + 3, SIG_ACT, 16'd0, "spd_zero_entry");
        step(2);
        VDPSPEEDMODE = 1'b1;
        for (int k = 4; k <= 8; k++) expect_at(s + k, SIG_ACT, 16'd1, "spd_on");
        step(5);
        n_checks = n_checks + 1;
        if (ACTIVE !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL spd_on_direct cyc=%0d actual=%b required=1", cyc, ACTIVE);
        end
        VDPSPEEDMODE = 1'b0;
        expect_at(s + 9,  SIG_ACT, 16'd0, "spd_off_now");
        expect_at(s + 10, SIG_ACT, 16'd0, "spd_off_next");
        step(1);
        step(1);

        // Mode change: one-cycle read latency, ACC survives the context switch
        m = cyc;
        REG_R1_DISP_ON = 1'b0;
        expect_at(m + 1, SIG_ACT, 16'd0, "mode_old_incr");
        expect_at(m + 2, SIG_ACT, 16'd1, "mode_blank_incr");
        step(2);
        REG_R1_DISP_ON = 1'b1;
        DRIVE          = 1'b0;
        expect_at(m + 3, SIG_ACT, 16'd1, "mode_acc_kept");
        step(1);
        DRIVE = 1'b1;
        expect_at(m + 4, SIG_ACT, 16'd0, "mode_zero_drive");
        step(1);
        DRIVE = 1'b0;

`ifdef VDP_THROTTLE_STATS_EN
        t = cyc;
        VDPSPEEDMODE = 1'b1;
        GRANT_CLR    = 1'b1;
        expect_at(t + 1, SIG_CNT, 16'd0, "cnt_clear");
        step(1);
        GRANT_CLR = 1'b0;
        DRIVE     = 1'b1;
        expect_at(t + 11,    SIG_CNT, 16'd10,    "cnt_ten");
        expect_at(t + 70001, SIG_CNT, 16'hFFFF, "cnt_saturate");
        step(70000);
        GRANT_CLR = 1'b1;
        expect_at(t + 70002, SIG_CNT, 16'd0, "cnt_clr_priority");
        step(1);
        GRANT_CLR    = 1'b0;
        DRIVE        = 1'b0;
        VDPSPEEDMODE = 1'b0;
        expect_at(t + 70003, SIG_CNT, 16'd0, "cnt_hold");
        step(1);
`endif

        step(2);
        while (sbq.size() > 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL %s cyc=%0d actual=unchecked required=due %0d", sbq[0].name, cyc, sbq[0].cyc);
            sbq.delete(0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
